// File: rtl/pc_branch_unit.sv
// Program-counter and branch unit for a 14-bit-instruction microcontroller core.
// Tracks the next fetch address, steers GOTO/CALL/RETURN/skip/PCL-write control
// flow, flags the already-fetched instruction for NOP execution after a taken
// branch, and keeps a circular return-address stack with sticky over/underflow flags.
module pc_branch_unit #(
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [13:0]      instr,
    input  logic             skip_cond,
    input  logic [4:0]       pclath,
    input  logic             pcl_write,
    input  logic [7:0]       pcl_data,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic [3:0]       stack_level,
    output logic             stack_ovf,
    output logic             stack_unf
);

    localparam int         PTR_W   = $clog2(STACK_DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(STACK_DEPTH);

    logic [PC_W-1:0]  pc_reg, pc_next;
    logic             flush_reg, flush_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_dec;
    logic [3:0]       level_reg, level_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             push;

    // Return-address storage; contents survive reset, only the pointer is cleared.
    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
    logic [PC_W-1:0]  pop_data;

    // Instruction classes of the currently executing instruction.
    logic is_goto, is_call, is_ret, is_skip;
    logic [PC_W-1:0] jump_target, pcl_target, pc_inc;

    assign is_goto = (instr[13:11] == 3'b101);
    assign is_call = (instr[13:11] == 3'b100);
    assign is_ret  = (instr == 14'h0008) || (instr == 14'h0009) || (instr[13:10] == 4'b1101);
    assign is_skip = (instr[13:8] == 6'h0B) || (instr[13:8] == 6'h0F) ||
                     (instr[13:10] == 4'b0110) || (instr[13:10] == 4'b0111);

    assign jump_target = PC_W'({pclath[4:3], instr[10:0]});
    assign pcl_target  = PC_W'({pclath, pcl_data});
    assign pc_inc      = pc_reg + 1'b1;

    // Pop pre-decrements the pointer, so the top entry sits just below it.
    assign ptr_dec  = ptr_reg - 1'b1;
    assign pop_data = stack_mem[ptr_dec];

    // Next-state decode for one instruction cycle; a pending flush beats decode.
    always_comb begin
        pc_next    = pc_reg;
        flush_next = flush_reg;
        ptr_next   = ptr_reg;
        level_next = level_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        if (flush_reg) begin
            pc_next    = pc_inc;
            flush_next = 1'b0;
        end else if (is_goto) begin
            pc_next    = jump_target;
            flush_next = 1'b1;
        end else if (is_call) begin
            push       = 1'b1;
            ptr_next   = ptr_reg + 1'b1;
            pc_next    = jump_target;
            flush_next = 1'b1;
            if (level_reg == DEPTH_L) begin
                ovf_next = 1'b1;
            end else begin
                level_next = level_reg + 1'b1;
            end
        end else if (is_ret) begin
            ptr_next   = ptr_dec;
            pc_next    = pop_data;
            flush_next = 1'b1;
            if (level_reg == 4'd0) begin
                unf_next = 1'b1;
            end else begin
                level_next = level_reg - 1'b1;
            end
        end else if (is_skip) begin
            pc_next    = pc_inc;
            flush_next = skip_cond;
        end else if (pcl_write) begin
            pc_next    = pcl_target;
            flush_next = 1'b1;
        end else begin
            pc_next    = pc_inc;
            flush_next = 1'b0;
        end
    end

    // Control state: reset wins regardless of advance, otherwise update only on advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= '0;
            flush_reg <= 1'b0;
            ptr_reg   <= '0;
            level_reg <= 4'd0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (advance) begin
            pc_reg    <= pc_next;
            flush_reg <= flush_next;
            ptr_reg   <= ptr_next;
            level_reg <= level_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Stack write: the return address is the current fetch address at the CALL.
    always_ff @(posedge clk) begin
        if (!reset && advance && push) begin
            stack_mem[ptr_reg] <= pc_reg;
        end
    end

    assign pc          = pc_reg;
    assign flush       = flush_reg;
    assign stack_level = level_reg;
    assign stack_ovf   = ovf_reg;
    assign stack_unf   = unf_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: the driver computes the expected outputs
// from an instruction-level model and queues them; the monitor pops one entry per
// clock edge and compares it with what the DUT presents.
module tb_pc_branch_unit;

    localparam int D  = 8;
    localparam int PW = 13;
    localparam int PM = 1 << PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          advance = 1'b0;
    logic [13:0]   instr = '0;
    logic          skip_cond = 1'b0;
    logic [4:0]    pclath = '0;
    logic          pcl_write = 1'b0;
    logic [7:0]    pcl_data = '0;
    logic [PW-1:0] pc;
    logic          flush;
    logic [3:0]    stack_level;
    logic          stack_ovf;
    logic          stack_unf;

    pc_branch_unit #(.STACK_DEPTH(D), .PC_W(PW)) dut (
        .clk(clk), .reset(reset), .advance(advance), .instr(instr),
        .skip_cond(skip_cond), .pclath(pclath), .pcl_write(pcl_write),
        .pcl_data(pcl_data), .pc(pc), .flush(flush), .stack_level(stack_level),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int pc;
        bit pc_known;
        bit flush;
        int level;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;
    int txn = 0;

    // Reference model state: an unbounded call-depth counter clipped to D, and a
    // D-entry ring addressed by a wrapping index (stale entries are returned on underflow).
    int m_pc = 0;
    bit m_pck = 1'b1;
    bit m_fl = 1'b0;
    int m_ptr = 0;
    int m_lvl = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int m_mem[D];
    bit m_known[D];

    task automatic model(input bit rst, input bit adv, input logic [13:0] ins,
                         input bit sk, input logic [4:0] pl, input bit pw,
                         input logic [7:0] pd);
        int target;
        target = (int'(pl) >> 3) * 2048 + (int'(ins) & 'h7FF);
        if (rst) begin
            m_pc = 0; m_pck = 1; m_fl = 0; m_ptr = 0; m_lvl = 0; m_ovf = 0; m_unf = 0;
        end else if (adv) begin
            if (m_fl) begin
                m_pc = (m_pc + 1) % PM; m_fl = 0;
            end else if (ins[13:11] == 3'b101) begin
                m_pc = target; m_pck = 1; m_fl = 1;
            end else if (ins[13:11] == 3'b100) begin
                m_mem[m_ptr] = m_pc; m_known[m_ptr] = m_pck;
                m_ptr = (m_ptr + 1) % D;
                if (m_lvl == D) m_ovf = 1; else m_lvl++;
                m_pc = target; m_pck = 1; m_fl = 1;
            end else if (ins == 14'h0008 || ins == 14'h0009 || ins[13:10] == 4'b1101) begin
                m_ptr = (m_ptr + D - 1) % D;
                m_pc = m_mem[m_ptr]; m_pck = m_known[m_ptr];
                if (m_lvl == 0) m_unf = 1; else m_lvl--;
                m_fl = 1;
            end else if (ins[13:8] == 6'h0B || ins[13:8] == 6'h0F ||
                         ins[13:10] == 4'b0110 || ins[13:10] == 4'b0111) begin
                m_pc = (m_pc + 1) % PM; m_fl = sk;
            end else if (pw) begin
                m_pc = int'(pl) * 256 + int'(pd); m_pck = 1; m_fl = 1;
            end else begin
                m_pc = (m_pc + 1) % PM; m_fl = 0;
            end
        end
    endtask

    // One clock cycle of stimulus: drive at the falling edge, queue what must follow.
    task automatic step(input bit rst, input bit adv, input logic [13:0] ins,
                        input bit sk, input logic [4:0] pl, input bit pw,
                        input logic [7:0] pd);
        exp_t e;
        @(negedge clk);
        reset = rst; advance = adv; instr = ins; skip_cond = sk;
        pclath = pl; pcl_write = pw; pcl_data = pd;
        model(rst, adv, ins, sk, pl, pw, pd);
        txn++;
        e.id = txn; e.pc = m_pc; e.pc_known = m_pck; e.flush = m_fl;
        e.level = m_lvl; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
    endtask

    task automatic adv_instr(input logic [13:0] ins, input logic [4:0] pl);
        step(1'b0, 1'b1, ins, 1'b0, pl, 1'b0, 8'h00);
    endtask

    task automatic check(input string name, input int id, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL txn %0d %s: got %0h, expected %0h", id, name, act, req);
        end
    endtask

    // Monitor: the DUT presents new registered outputs after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.pc_known) check("pc", e.id, int'(pc), e.pc);
                check("flush", e.id, int'(flush), int'(e.flush));
                check("stack_level", e.id, int'(stack_level), e.level);
                check("stack_ovf", e.id, int'(stack_ovf), int'(e.ovf));
                check("stack_unf", e.id, int'(stack_unf), int'(e.unf));
                $display("txn %0d: pc=%04h flush=%0d level=%0d ovf=%0d unf=%0d",
                         e.id, pc, flush, stack_level, stack_ovf, stack_unf);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized instruction streams.
    initial begin
        logic [13:0] ri;
        logic [10:0] r11;
        logic [9:0]  r10;
        logic [7:0]  r8;
        for (int i = 0; i < D; i++) begin
            m_mem[i] = 0;
            m_known[i] = 1'b0;
        end

        // Reset state, with and without advance.
        step(1'b1, 1'b0, 14'h0000, 1'b0, 5'h00, 1'b0, 8'h00);
        step(1'b1, 1'b1, 14'h2855, 1'b0, 5'h00, 1'b0, 8'h00);
        // Linear run of NOPs.
        for (int i = 0; i < 5; i++) adv_instr(14'h0000, 5'h00);
        // GOTO with page bits from pclath, then its flush cycle.
        adv_instr(14'h2855, 5'b01000);
        adv_instr(14'h0000, 5'b01000);
        // Reach pc=0x010, CALL 0x100, RETURN back.
        adv_instr(14'h280F, 5'h00);
        adv_instr(14'h0000, 5'h00);
        adv_instr(14'h2100, 5'h00);
        adv_instr(14'h0008, 5'h00);
        adv_instr(14'h0008, 5'h00);
        adv_instr(14'h0000, 5'h00);
        // DECFSZ at pc=0x020 taken, then not taken.
        adv_instr(14'h281F, 5'h00);
        adv_instr(14'h0000, 5'h00);
        step(1'b0, 1'b1, 14'h0B20, 1'b1, 5'h00, 1'b0, 8'h00);
        adv_instr(14'h0000, 5'h00);
        step(1'b0, 1'b1, 14'h0B20, 1'b0, 5'h00, 1'b0, 8'h00);
        // PCL write, also ignored during a flush cycle.
        step(1'b0, 1'b1, 14'h0782, 1'b0, 5'h1F, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 14'h0782, 1'b1, 5'h03, 1'b1, 8'h11);
        // Increment wrap at the top of the address space.
        adv_instr(14'h2FFF, 5'b11000);
        adv_instr(14'h0000, 5'h00);
        // Nine nested CALLs overflow the stack, then nine RETURNs unwind and underflow.
        for (int i = 0; i < 9; i++) begin
            adv_instr(14'h2000 | 14'(16 * (i + 1)), 5'h00);
            adv_instr(14'h0000, 5'h00);
        end
        for (int i = 0; i < 9; i++) begin
            adv_instr(14'h0008, 5'h00);
            adv_instr(14'h0000, 5'h00);
        end
        // Hold: no advance, busy inputs.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 14'h2123, 1'b1, 5'h1F, 1'b1, 8'hFF);
        // Reset while a flush is pending, and reset in the cycle of a CALL.
        adv_instr(14'h2800, 5'h00);
        step(1'b1, 1'b1, 14'h2000, 1'b0, 5'h00, 1'b0, 8'h00);
        adv_instr(14'h2400, 5'h00);
        step(1'b1, 1'b1, 14'h2400, 1'b0, 5'h00, 1'b0, 8'h00);

        // Randomized instruction mix.
        for (int n = 0; n < 600; n++) begin
            r11 = 11'($urandom);
            r10 = 10'($urandom);
            r8  = 8'($urandom);
            case ($urandom_range(0, 9))
                0: ri = {3'b101, r11};
                1: ri = {3'b100, r11};
                2: ri = 14'h0008;
                3: ri = 14'h0009;
                4: ri = {4'b1101, r10};
                5: ri = {6'h0B, r8};
                6: ri = {6'h0F, r8};
                7: ri = {3'b011, r11};
                default: ri = 14'($urandom);
            endcase
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80), ri,
                 1'($urandom), 5'($urandom), ($urandom_range(0, 99) < 30), 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, number of return-address stack entries.
REQ-002 SHALL have parameter PC_W, default 13, program counter width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 advance  input  1  one-cycle instruction-cycle strobe; state SHALL update only on edges where advance=1.
REQ-006 instr  input  14  instruction currently executing, i.e. fetched on the previous advance.
REQ-007 skip_cond  input  1  zero or bit-test result from the ALU for the current instr.
REQ-008 pclath  input  5  PCLATH register value.
REQ-009 pcl_write  input  1  current instruction writes PCL.
REQ-010 pcl_data  input  8  value written to PCL.
REQ-011 pc  output  PC_W  address of the next fetch, registered.
REQ-012 flush  output  1  registered; the instruction fetched at this pc SHALL execute as NOP.
REQ-013 stack_level  output  4  number of valid stack entries, 0..STACK_DEPTH, saturating.
REQ-014 stack_ovf  output  1  sticky flag; push occurred while stack_level=STACK_DEPTH.
REQ-015 stack_unf  output  1  sticky flag; pop occurred while stack_level=0.

Function
REQ-016 With advance=0, pc, flush, stack contents, pointer, level and flags SHALL all hold.
REQ-017 Priority on each advance: reset, then flush, then instruction decode.
REQ-018 If flush=1: pc<=pc+1; flush<=0; no stack operation; instr, skip_cond and pcl_write SHALL be ignored.
REQ-019 GOTO (instr[13:11]=3'b101): pc<={pclath[4:3],instr[10:0]}; flush<=1.
REQ-020 CALL (instr[13:11]=3'b100): push pc; pc<={pclath[4:3],instr[10:0]}; flush<=1.
REQ-021 RETURN (14'h0008), RETFIE (14'h0009) and RETLW (instr[13:10]=4'b1101): pc<=popped value; flush<=1.
REQ-022 DECFSZ (instr[13:8]=6'h0B), INCFSZ (6'h0F), BTFSC (instr[13:10]=4'b0110), BTFSS (4'b0111): if skip_cond=1, pc<=pc+1 and flush<=1; otherwise pc<=pc+1 and flush<=0.
REQ-023 pcl_write=1 on any other instruction: pc<={pclath[4:0],pcl_data}; flush<=1.
REQ-024 All other instructions: pc<=pc+1; flush<=0.
REQ-025 Increment SHALL wrap modulo 2^PC_W: 13'h1FFF+1 gives 13'h0000.
REQ-026 Stack SHALL be a circular buffer of STACK_DEPTH entries of PC_W bits, with a 3-bit pointer that wraps.
REQ-027 Push SHALL write the entry at the pointer and then increment the pointer.
REQ-028 Pop SHALL decrement the pointer and then read the entry there.
REQ-029 Push at stack_level=STACK_DEPTH SHALL overwrite the oldest entry, hold stack_level at STACK_DEPTH, and set stack_ovf.
REQ-030 Pop at stack_level=0 SHALL still decrement the pointer and return that entry's contents, hold stack_level at 0, and set stack_unf.
REQ-031 Push and pop SHALL never occur on the same advance.

Reset
REQ-032 On reset=1 at a clock edge, regardless of advance: pc=0, flush=0, pointer=0, stack_level=0, stack_ovf=0, stack_unf=0.
REQ-033 Stack contents need not be cleared on reset.
REQ-034 Reset mid-CALL or mid-flush SHALL discard the pending operation.
REQ-035 Reset asserted with advance=1 SHALL take priority over all decode.

Verification
REQ-036 Linear run: reset, then 5 advances of NOP (14'h0000) -> pc=5, flush=0 throughout.
REQ-037 GOTO: pclath=5'b01000 (pclath[4:3]=2'b01), instr=14'h2855 -> pc=13'h0855, flush=1; next advance -> pc=13'h0856, flush=0.
REQ-038 CALL then RETURN: with pc=13'h0010, instr=14'h2100 -> pc=13'h0100, stack_level=1. After the flush advance, RETURN -> pc=13'h0010, stack_level=0, flush=1.
REQ-039 Skip: DECFSZ 14'h0B20 with skip_cond=1 at pc=13'h0020 -> pc=13'h0021, flush=1; the same instruction with skip_cond=0 -> flush=0.
REQ-040 Overflow: 9 CALLs, each followed by its flush advance -> stack_level=8, stack_ovf=1; the first RETURN yields the 9th return address, and 8 RETURNs yield the 2nd address last.
REQ-041 Underflow and hold: RETURN at stack_level=0 -> stack_unf=1, stack_level=0. With advance=0 for 3 cycles, all outputs are unchanged. Reset during flush=1 -> pc=0, flush=0.
